// File: rtl/mmix_defs.sv
// rtl/mmix_defs.sv - shared MMIX memory-port types and helpers
//
// Purpose: access-size and bridge-state enums plus the helper that gives the
// highest request byte-address bit a backend of a given word width decodes.
// Ports: none (package).

package mmix_defs;

  typedef enum logic [1:0] {
    MS_BYTE  = 2'd0,
    MS_WYDE  = 2'd1,
    MS_TETRA = 2'd2,
    MS_OCTA  = 2'd3
  } mem_size_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RDV0,
    S_RD1,
    S_RDV1,
    S_WR0,
    S_WR1,
    S_DONE
  } bridge_state_t;

  // A backend addressing 2**av_addr_width tetras decodes byte-address bits
  // [av_addr_width+1:0]; this returns the top one of those.
  function automatic int mem_hi_bit(input int av_addr_width);
    return av_addr_width + 1;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// rtl/mem_lane_steer.sv - big-endian lane steering for a 32-bit bus
//
// Purpose: maps an MMIX access (size, low address bits) onto a 32-bit
// big-endian data bus where lane [31:24] holds the lowest byte address.
// Ports:
//   size        in  2   access size (mem_size_t encoding)
//   addr_lo     in  2   aligned byte address bits [1:0]
//   beat        in  1   octa second beat (low tetra of the store data)
//   wdata       in  64  right-justified store data
//   rdata       in  32  bus read data
//   byteenable  out 4   bus byte enables
//   wlanes      out 32  bus write data
//   rextract    out 32  addressed lane(s) shifted to bit 0, zero-filled

module mem_lane_steer
  import mmix_defs::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        beat,
  input  logic [63:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wlanes,
  output logic [31:0] rextract
);

  always_comb begin
    byteenable = 4'b1111;
    wlanes     = wdata[31:0];
    rextract   = rdata;
    case (size)
      MS_BYTE: begin
        byteenable = 4'b1000 >> addr_lo;
        wlanes     = {4{wdata[7:0]}};
        // Byte at address a sits at bit 8*(3-a); 3-a is ~a for two bits.
        rextract   = {24'b0, 8'(rdata >> {~addr_lo, 3'b000})};
      end
      MS_WYDE: begin
        byteenable = addr_lo[1] ? 4'b0011 : 4'b1100;
        wlanes     = {2{wdata[15:0]}};
        rextract   = {16'b0, (addr_lo[1] ? rdata[15:0] : rdata[31:16])};
      end
      MS_TETRA: begin
        byteenable = 4'b1111;
        wlanes     = wdata[31:0];
      end
      MS_OCTA: begin
        byteenable = 4'b1111;
        // Big-endian: the high tetra lives at the lower word address.
        wlanes     = beat ? wdata[31:0] : wdata[63:32];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - MMIX memory port to 32-bit Avalon-MM bridge
//
// Purpose: services one byte/wyde/tetra/octa request at a time from the
// execution unit over a 32-bit Avalon-MM master; octas take two tetra beats.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (out-of-range requests fault
// without touching the backend).
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   mem_address/datasize/read/write   request from initiator (levels)
//   mem_writedata, mem_readdata       right-justified store/load data
//   mem_done, mem_fault               one-cycle completion / fault pulses
//   av_*                              Avalon-MM master to SDRAM controller

module data_mem_bridge
  import mmix_defs::*;
#(
  parameter int AV_ADDR_WIDTH = 21
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [63:0]              mem_address,
  input  logic [1:0]               mem_datasize,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [63:0]              mem_writedata,
  output logic [63:0]              mem_readdata,
  output logic                     mem_done,
  output logic                     mem_fault,
  output logic [AV_ADDR_WIDTH-1:0] av_address,
  output logic [3:0]               av_byteenable,
  output logic                     av_read,
  output logic                     av_write,
  output logic [31:0]              av_writedata,
  input  logic [31:0]              av_readdata,
  input  logic                     av_waitrequest,
  input  logic                     av_readdatavalid
);

  localparam int HI = mem_hi_bit(AV_ADDR_WIDTH);

  bridge_state_t state, next_state;

  mem_size_t   size_q;
  logic [1:0]  lo_q;
  logic [63:0] wdata_q;
  logic        is_write_q;
  logic [31:0] hi_q;

  logic        req;
  logic        req_live;
  logic        beat;
  logic        oor;
  logic [2:0]  lo_aligned;
  logic [3:0]  steer_be;
  logic [31:0] steer_wd;
  logic [31:0] steer_rd;

  assign req = mem_read | mem_write;
  // The initiator keeps the sampled request high until mem_done; dropping
  // it earlier withdraws the request.
  assign req_live = is_write_q ? mem_write : mem_read;
  assign beat = (state == S_RD1) || (state == S_RDV1) || (state == S_WR1);

`ifdef MEM_BOUNDS_CHECK_EN
  logic fault_q;
  assign oor = |mem_address[63:HI+1];
`else
  logic unused_hi;
  assign unused_hi = |mem_address[63:HI+1];
  assign oor = 1'b0;
`endif

  // Align down to the access size; bits above [2] never change.
  always_comb begin
    lo_aligned = mem_address[2:0];
    case (mem_size_t'(mem_datasize))
      MS_BYTE:  lo_aligned = mem_address[2:0];
      MS_WYDE:  lo_aligned = {mem_address[2:1], 1'b0};
      MS_TETRA: lo_aligned = {mem_address[2], 2'b00};
      MS_OCTA:  lo_aligned = 3'b000;
      default:  ;
    endcase
  end

  mem_lane_steer u_steer (
    .size       (size_q),
    .addr_lo    (lo_q),
    .beat       (beat),
    .wdata      (wdata_q),
    .rdata      (av_readdata),
    .byteenable (steer_be),
    .wlanes     (steer_wd),
    .rextract   (steer_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state    = state;
    av_read       = 1'b0;
    av_write      = 1'b0;
    av_byteenable = 4'b0000;
    av_writedata  = 32'b0;
    mem_done      = 1'b0;
    mem_fault     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (oor)            next_state = S_DONE;
          else if (mem_write) next_state = S_WR0;
          else                next_state = S_RD0;
        end
      end
      S_WR0: begin
        av_write      = 1'b1;
        av_byteenable = steer_be;
        av_writedata  = steer_wd;
        if (!av_waitrequest) begin
          if (!req_live)               next_state = S_IDLE;
          else if (size_q == MS_OCTA)  next_state = S_WR1;
          else                         next_state = S_DONE;
        end
      end
      S_WR1: begin
        av_write      = 1'b1;
        av_byteenable = steer_be;
        av_writedata  = steer_wd;
        if (!av_waitrequest) next_state = req_live ? S_DONE : S_IDLE;
      end
      S_RD0: begin
        av_read       = 1'b1;
        av_byteenable = steer_be;
        if (!av_waitrequest) next_state = S_RDV0;
      end
      S_RDV0: begin
        if (av_readdatavalid) begin
          if (!req_live)               next_state = S_IDLE;
          else if (size_q == MS_OCTA)  next_state = S_RD1;
          else                         next_state = S_DONE;
        end
      end
      S_RD1: begin
        av_read       = 1'b1;
        av_byteenable = steer_be;
        if (!av_waitrequest) next_state = S_RDV1;
      end
      S_RDV1: begin
        if (av_readdatavalid) next_state = req_live ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        mem_done   = 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
        mem_fault  = fault_q;
`endif
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q       <= MS_BYTE;
      lo_q         <= 2'b00;
      wdata_q      <= 64'b0;
      is_write_q   <= 1'b0;
      hi_q         <= 32'b0;
      av_address   <= '0;
      mem_readdata <= 64'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && req) begin
        size_q     <= mem_size_t'(mem_datasize);
        lo_q       <= lo_aligned[1:0];
        wdata_q    <= mem_writedata;
        is_write_q <= mem_write;
        av_address <= {mem_address[HI:3], lo_aligned[2]};
`ifdef MEM_BOUNDS_CHECK_EN
        fault_q    <= oor;
        if (oor && !mem_write) mem_readdata <= 64'b0;
`endif
      end
      // Octa second beat targets the next tetra.
      if ((state == S_WR0 && next_state == S_WR1) ||
          (state == S_RDV0 && next_state == S_RD1))
        av_address <= av_address + 1'b1;
      if (state == S_RDV0 && next_state == S_RD1)
        hi_q <= av_readdata;
      // Load data only changes when a read actually completes.
      if ((state == S_RDV0 || state == S_RDV1) && next_state == S_DONE)
        mem_readdata <= (size_q == MS_OCTA) ? {hi_q, av_readdata}
                                            : {32'b0, steer_rd};
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - directed self-checking bench for data_mem_bridge

module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata;
  logic        mem_done;
  logic        mem_fault;
  logic [20:0] av_address;
  logic [3:0]  av_byteenable;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic        av_readdatavalid;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;

  data_mem_bridge #(.AV_ADDR_WIDTH(21)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_address      (mem_address),
    .mem_datasize     (mem_datasize),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata),
    .mem_done         (mem_done),
    .mem_fault        (mem_fault),
    .av_address       (av_address),
    .av_byteenable    (av_byteenable),
    .av_read          (av_read),
    .av_write         (av_write),
    .av_writedata     (av_writedata),
    .av_readdata      (av_readdata),
    .av_waitrequest   (av_waitrequest),
    .av_readdatavalid (av_readdatavalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_done) done_cnt++;

  // Inputs change and outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0;
    av_readdatavalid = 1'b0; av_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_address = 64'h0; mem_datasize = 2'd0; mem_writedata = 64'h0;
    av_readdata = 32'h0;
    idle_inputs();
    tick(); tick();
    n_checks++;
    if ({mem_readdata, mem_done, mem_fault, av_address, av_byteenable, av_read, av_write, av_writedata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd=%h done=%b fault=%b addr=%h be=%b r=%b w=%b wd=%h, all must be 0",
               mem_readdata, mem_done, mem_fault, av_address, av_byteenable, av_read, av_write, av_writedata);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({mem_done, av_read, av_write} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release_idle: done/r/w=%b want 000", {mem_done, av_read, av_write});
    end
  endtask

  task automatic test_write_byte();
    mem_write = 1'b1; mem_datasize = 2'd0; mem_address = 64'h1003; mem_writedata = 64'hAB;
    tick();
    n_checks++;
    if ({av_write, av_read, mem_done} !== 3'b100) begin
      n_fail++; $display("FAIL wb_strobe: w/r/done=%b want 100", {av_write, av_read, mem_done});
    end
    n_checks++;
    if (av_address !== 21'h400) begin n_fail++; $display("FAIL wb_addr: got %h want 400", av_address); end
    n_checks++;
    if (av_byteenable !== 4'b0001) begin n_fail++; $display("FAIL wb_be: got %b want 0001", av_byteenable); end
    n_checks++;
    if (av_writedata !== 32'hABABABAB) begin n_fail++; $display("FAIL wb_data: got %h want abababab", av_writedata); end
    tick();
    n_checks++;
    if ({mem_done, av_write} !== 2'b10) begin
      n_fail++; $display("FAIL wb_done: done/w=%b want 10", {mem_done, av_write});
    end
    mem_write = 1'b0;
    tick();
    n_checks++;
    if (mem_done !== 1'b0) begin n_fail++; $display("FAIL wb_done_pulse: done=%b want 0", mem_done); end
  endtask

  task automatic test_write_octa();
    int d0;
    d0 = done_cnt;
    mem_write = 1'b1; mem_datasize = 2'd3; mem_address = 64'h2005; mem_writedata = 64'h1122334455667788;
    tick();
    n_checks++;
    if ({av_write, av_address, av_byteenable, av_writedata} !== {1'b1, 21'h800, 4'hF, 32'h11223344}) begin
      n_fail++; $display("FAIL wo_beat0: w=%b addr=%h be=%b data=%h want 1 800 1111 11223344",
                         av_write, av_address, av_byteenable, av_writedata);
    end
    tick();
    n_checks++;
    if ({av_write, av_address, av_byteenable, av_writedata, mem_done} !== {1'b1, 21'h801, 4'hF, 32'h55667788, 1'b0}) begin
      n_fail++; $display("FAIL wo_beat1: w=%b addr=%h be=%b data=%h done=%b want 1 801 1111 55667788 0",
                         av_write, av_address, av_byteenable, av_writedata, mem_done);
    end
    tick();
    n_checks++;
    if ({mem_done, av_write} !== 2'b10) begin n_fail++; $display("FAIL wo_done: done/w=%b want 10", {mem_done, av_write}); end
    mem_write = 1'b0;
    tick(); tick();
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL wo_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_read_wyde();
    mem_read = 1'b1; mem_datasize = 2'd1; mem_address = 64'h0102;
    tick();
    n_checks++;
    if ({av_read, av_write, av_address, av_byteenable} !== {1'b1, 1'b0, 21'h40, 4'b0011}) begin
      n_fail++; $display("FAIL rw_strobe: r=%b w=%b addr=%h be=%b want 1 0 40 0011", av_read, av_write, av_address, av_byteenable);
    end
    tick();
    n_checks++;
    if (av_read !== 1'b0) begin n_fail++; $display("FAIL rw_single_strobe: r=%b want 0", av_read); end
    av_readdatavalid = 1'b1; av_readdata = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({mem_done, mem_readdata} !== {1'b1, 64'h000000000000BEEF}) begin
      n_fail++; $display("FAIL rw_data: done=%b rd=%h want 1 000000000000beef", mem_done, mem_readdata);
    end
    av_readdatavalid = 1'b0; mem_read = 1'b0;
    tick();
    n_checks++;
    if ({mem_done, mem_readdata} !== {1'b0, 64'h000000000000BEEF}) begin
      n_fail++; $display("FAIL rw_hold: done=%b rd=%h want 0 000000000000beef", mem_done, mem_readdata);
    end
  endtask

  task automatic test_read_byte_lane();
    mem_read = 1'b1; mem_datasize = 2'd0; mem_address = 64'h0003;
    tick();
    n_checks++;
    if (av_byteenable !== 4'b0001) begin n_fail++; $display("FAIL rb_be: got %b want 0001", av_byteenable); end
    tick();
    av_readdatavalid = 1'b1; av_readdata = 32'h11223344;
    tick();
    n_checks++;
    if ({mem_done, mem_readdata} !== {1'b1, 64'h44}) begin
      n_fail++; $display("FAIL rb_data: done=%b rd=%h want 1 0000000000000044", mem_done, mem_readdata);
    end
    av_readdatavalid = 1'b0; mem_read = 1'b0;
    tick();
  endtask

  task automatic test_read_octa_stall();
    int d0;
    d0 = done_cnt;
    mem_read = 1'b1; mem_datasize = 2'd3; mem_address = 64'h10; av_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({av_read, av_address, av_byteenable} !== {1'b1, 21'h4, 4'hF}) begin
        n_fail++; $display("FAIL ro_stall_%0d: r=%b addr=%h be=%b want 1 4 1111", i, av_read, av_address, av_byteenable);
      end
      if (i == 2) av_waitrequest = 1'b0;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({av_read, mem_done} !== 2'b00) begin
        n_fail++; $display("FAIL ro_wait_rdv_%0d: r/done=%b want 00", i, {av_read, mem_done});
      end
      tick();
    end
    av_readdatavalid = 1'b1; av_readdata = 32'hCAFEF00D;
    tick();
    av_readdatavalid = 1'b0;
    n_checks++;
    if ({av_read, av_address, av_byteenable} !== {1'b1, 21'h5, 4'hF}) begin
      n_fail++; $display("FAIL ro_beat1: r=%b addr=%h be=%b want 1 5 1111", av_read, av_address, av_byteenable);
    end
    tick();
    av_readdatavalid = 1'b1; av_readdata = 32'h12345678;
    tick();
    n_checks++;
    if ({mem_done, mem_readdata} !== {1'b1, 64'hCAFEF00D12345678}) begin
      n_fail++; $display("FAIL ro_data: done=%b rd=%h want 1 cafef00d12345678", mem_done, mem_readdata);
    end
    av_readdatavalid = 1'b0; mem_read = 1'b0;
    tick(); tick();
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ro_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_withdraw();
    int d0;
    d0 = done_cnt;
    mem_write = 1'b1; mem_datasize = 2'd3; mem_address = 64'h0; mem_writedata = 64'h0102030405060708;
    av_waitrequest = 1'b1;
    tick();
    mem_write = 1'b0;
    #1;
    n_checks++;
    if ({av_write, av_writedata} !== {1'b1, 32'h01020304}) begin
      n_fail++; $display("FAIL wd_held: w=%b data=%h want 1 01020304", av_write, av_writedata);
    end
    av_waitrequest = 1'b0;
    tick();
    n_checks++;
    if (av_write !== 1'b0) begin n_fail++; $display("FAIL wd_no_beat1: w=%b want 0", av_write); end
    tick();
    n_checks++;
    if ({av_write, done_cnt - d0} !== {1'b0, 32'd0}) begin
      n_fail++; $display("FAIL wd_no_done: w=%b dones=%0d want 0 0", av_write, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    mem_read = 1'b1; mem_datasize = 2'd2; mem_address = 64'h20;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({av_read, av_write, mem_done, mem_readdata} !== '0) begin
      n_fail++; $display("FAIL rm_async: r=%b w=%b done=%b rd=%h want all 0", av_read, av_write, mem_done, mem_readdata);
    end
    mem_read = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    av_readdatavalid = 1'b1; av_readdata = 32'hBAD0BAD0;
    tick();
    av_readdatavalid = 1'b0;
    tick();
    n_checks++;
    if ({mem_readdata, done_cnt - d0} !== {64'h0, 32'd0}) begin
      n_fail++; $display("FAIL rm_late_rdv: rd=%h dones=%0d want 0 0", mem_readdata, done_cnt - d0);
    end
    mem_read = 1'b1; mem_address = 64'h24;
    tick();
    n_checks++;
    if ({av_read, av_address} !== {1'b1, 21'h9}) begin
      n_fail++; $display("FAIL rm_next_addr: r=%b addr=%h want 1 9", av_read, av_address);
    end
    tick();
    av_readdatavalid = 1'b1; av_readdata = 32'h0BADF00D;
    tick();
    n_checks++;
    if ({mem_done, mem_readdata} !== {1'b1, 64'h000000000BADF00D}) begin
      n_fail++; $display("FAIL rm_next_data: done=%b rd=%h want 1 000000000badf00d", mem_done, mem_readdata);
    end
    av_readdatavalid = 1'b0; mem_read = 1'b0;
    tick();
  endtask

  task automatic test_write_wins();
    mem_read = 1'b1; mem_write = 1'b1; mem_datasize = 2'd2; mem_address = 64'h0B; mem_writedata = 64'hFFFF_FFFF_A5A5_5A5A;
    tick();
    n_checks++;
    if ({av_write, av_read, av_address, av_writedata} !== {1'b1, 1'b0, 21'h2, 32'hA5A55A5A}) begin
      n_fail++; $display("FAIL ww_strobe: w=%b r=%b addr=%h data=%h want 1 0 2 a5a55a5a", av_write, av_read, av_address, av_writedata);
    end
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
  endtask

  task automatic test_high_addr();
    mem_read = 1'b1; mem_datasize = 2'd2; mem_address = 64'h0100_0000_0000_0000;
    tick();
`ifdef MEM_BOUNDS_CHECK_EN
    n_checks++;
    if ({av_read, mem_done, mem_fault, mem_readdata} !== {1'b0, 1'b1, 1'b1, 64'h0}) begin
      n_fail++; $display("FAIL ha_fault: r=%b done=%b fault=%b rd=%h want 0 1 1 0", av_read, mem_done, mem_fault, mem_readdata);
    end
`else
    n_checks++;
    if ({av_read, av_address} !== {1'b1, 21'h0}) begin
      n_fail++; $display("FAIL ha_alias: r=%b addr=%h want 1 0", av_read, av_address);
    end
    tick();
    av_readdatavalid = 1'b1; av_readdata = 32'h55AA55AA;
    tick();
    n_checks++;
    if ({mem_done, mem_fault, mem_readdata} !== {1'b1, 1'b0, 64'h55AA55AA}) begin
      n_fail++; $display("FAIL ha_read: done=%b fault=%b rd=%h want 1 0 0000000055aa55aa", mem_done, mem_fault, mem_readdata);
    end
    av_readdatavalid = 1'b0;
`endif
    mem_read = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_byte();
    test_write_octa();
    test_read_wyde();
    test_read_byte_lane();
    test_read_octa_stall();
    test_withdraw();
    test_reset_mid();
    test_write_wins();
    test_high_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
